rc5_key_sched_8bit: RTL and testbench
=====================================

# rc5_key_sched_8bit

RC5-8/ROUNDS/KEY_BYTES key-expansion engine feeding the 16-bit RC5 encryptor (two 8-bit words per block). On request it captures a secret key, builds the expanded subkey table S[0..2·ROUNDS+1] with the standard RC5 init-and-mix algorithm, and presents the table through a combinational read port. The encryptor may use the table only while `ks_valid` is high.

## Interface
- `ROUNDS`, 12, RC5 round count r; table size T = 2·(ROUNDS+1) (26 at default).
- `KEY_BYTES`, 8, key length b in bytes; L-array length C = KEY_BYTES (u = 1).
- `clock` input 1: the single clock; all state updates on its rising edge.
- `reset` input 1: asynchronous, active-low; low forces the reset state immediately.
- `ks_start` input 1: expansion request, sampled only in IDLE.
- `key` input 8·KEY_BYTES: secret key; L[k] = key[8k+7:8k].
- `s_addr` input $clog2(T): subkey read index.
- `s_data` output 8: S[s_addr], combinational; 0x00 when s_addr ≥ T.
- `ks_busy` output 1: high in INIT and MIX.
- `ks_done` output 1: registered one-cycle completion pulse.
- `ks_valid` output 1: table complete and stable.

## Operation
- States: IDLE → INIT → MIX → DONE → IDLE.
- IDLE: `ks_start`=1 at edge E0 → capture `key` into L, clear `ks_valid`, set i=0, go INIT. Later `key` changes have no effect.
- INIT: one entry per cycle, S[i] = P8 + i·Q8 mod 2^8, with P8=0xB7, Q8=0x9F; after i=T-1, reset i=j=0, A=B=0, go MIX.
- MIX: N = 3·max(T,C) steps, one per cycle (78 at default):
  - A = S[i] = ROTL8(S[i]+A+B, 3).
  - B = L[j] = ROTL8(L[j]+A+B, (A+B) mod 8), using the new A.
  - i = (i+1) mod T; j = (j+1) mod C.
  - After step N, go DONE.
- DONE: `ks_done`=1 and `ks_valid`=1 for one cycle, then IDLE with `ks_valid` held until the next accepted start or reset.
- All additions are mod 2^8. Rotate amounts are taken mod 8.
- `ks_start` in INIT, MIX or DONE is ignored. No queueing.
- `s_data` during busy returns the in-progress table. Consumers gate on `ks_valid`.
- Reset:
  - S, L, A, B, i, j cleared; state IDLE.
  - `ks_busy`=`ks_done`=`ks_valid`=0; `s_data` reads 0x00.
  - Reset mid-expansion aborts; no `ks_done` is produced.

## Timing
- Edge E0 accepts the start. Edges E1..ET write S[0..T-1].
- Edges E(T+1)..E(T+N) perform the mix steps.
- The outputs follow from those edges:
  - `ks_done` and `ks_valid` rise after edge E(T+N) (E104 at default).
  - `ks_done` falls after E(T+N+1).
  - `ks_busy` is high from after E0 until after E(T+N).
- A start is accepted the cycle after DONE at the earliest.
- `s_data` has zero-cycle read latency.

## Structure
- Package `rc5_pkg`:
  - W=8, P8, Q8.
  - `rotl8(value, amount)` function.
  - Key-schedule state enum.
- Shared with the encryptor and decryptor.
- No sub-module. S and L are register arrays local to the block.

## Test plan
- Reset, then release with no start → `ks_busy`=`ks_done`=`ks_valid`=0; `s_data`=0x00 for every address.
- Key all-zero, start → after E26: S[0]=0xB7, S[1]=0x56, S[25]=0x3E. After E27: S[0]=0xBD and L[0]=0xB7.
- Key all-zero, then 0xFFFF_FFFF_FFFF_FFFF, then a random key → `ks_done` is exactly one pulse after E104. The full S table matches the bench reference model.
- Pulse `ks_start` at E10 and E50 during busy → exactly one `ks_done` at E104. The table equals the single-run result.
- Drop `reset` at E60, then restart → no `ks_done`, `ks_valid`=0 immediately, table cleared. The restarted run completes correctly 104 cycles after the new E0.
- Hold the old key after done, then start with a new key → `ks_valid` falls after the new E0. The new table is valid after the new E104. `s_addr`=26..31 returns 0x00.

Source files
------------

// File: rtl/rc5_pkg.sv
// Shared RC5-8 definitions: word size, magic constants, rotate helper and
// key-schedule state encoding. Used by the key schedule, encryptor and decryptor.
package rc5_pkg;

  localparam int unsigned W = 8;

  // RC5 magic constants truncated to an 8-bit word.
  localparam logic [W-1:0] P8 = 8'hB7;
  localparam logic [W-1:0] Q8 = 8'h9F;

  typedef enum logic [1:0] {
    StIdle,
    StInit,
    StMix,
    StDone
  } ks_state_e;

  // Rotate left; the upper half of the doubled word holds the rotated value.
  function automatic logic [W-1:0] rotl8(input logic [W-1:0] value, input logic [2:0] amount);
    logic [2*W-1:0] dbl;
    dbl = {value, value} << amount;
    return dbl[2*W-1:W];
  endfunction

endpackage

// File: rtl/rc5_key_sched_8bit_if.sv
// Request / table-read bundle between the key schedule and its consumer.
interface rc5_key_sched_8bit_if #(
  parameter int unsigned ROUNDS    = 12,
  parameter int unsigned KEY_BYTES = 8
);

  localparam int unsigned T  = 2 * (ROUNDS + 1);
  localparam int unsigned AW = $clog2(T);

  logic                   ks_start;
  logic [8*KEY_BYTES-1:0] key;
  logic [AW-1:0]          s_addr;
  logic [7:0]             s_data;
  logic                   ks_busy;
  logic                   ks_done;
  logic                   ks_valid;

  // Consumer side: requests expansion and reads the subkey table.
  modport master (
    output ks_start, key, s_addr,
    input  s_data, ks_busy, ks_done, ks_valid
  );

  // Key-schedule side.
  modport slave (
    input  ks_start, key, s_addr,
    output s_data, ks_busy, ks_done, ks_valid
  );

endinterface

// File: rtl/rc5_key_sched_8bit.sv
// RC5-8 key expansion: captures the key, fills S with P8 + i*Q8, then runs
// 3*max(T,C) mix steps one per cycle. S is readable combinationally at all times.
module rc5_key_sched_8bit
  import rc5_pkg::*;
#(
  parameter int unsigned ROUNDS    = 12,
  parameter int unsigned KEY_BYTES = 8
) (
  input logic                clock,
  input logic                reset,
  rc5_key_sched_8bit_if.slave bus
);

  localparam int unsigned T  = 2 * (ROUNDS + 1);
  localparam int unsigned C  = KEY_BYTES;
  localparam int unsigned N  = 3 * ((T > C) ? T : C);
  localparam int unsigned AW = $clog2(T);
  localparam int unsigned JW = (C > 1) ? $clog2(C) : 1;
  localparam int unsigned NW = $clog2(N + 1);

  localparam logic [AW-1:0] ILast = AW'(T - 1);
  localparam logic [JW-1:0] JLast = JW'(C - 1);
  localparam logic [NW-1:0] NLast = NW'(N - 1);

  ks_state_e     state_q;
  logic [W-1:0]  s_q [T];
  logic [W-1:0]  l_q [C];
  logic [W-1:0]  a_q, b_q;
  logic [AW-1:0] i_q;
  logic [JW-1:0] j_q;
  logic [NW-1:0] step_q;
  logic          busy_q, done_q, valid_q;

  logic [W-1:0]  sum_a, a_new, sum_b, b_new;
  logic [2:0]    b_amt;

  // One mix step: new A feeds straight into the B update.
  always_comb begin
    sum_a = s_q[i_q] + a_q + b_q;
    a_new = rotl8(sum_a, 3'd3);
    sum_b = l_q[j_q] + a_new + b_q;
    b_amt = a_new[2:0] + b_q[2:0];
    b_new = rotl8(sum_b, b_amt);
  end

  // Controller, table and key registers with registered status outputs.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
      for (int k = 0; k < T; k++) s_q[k] <= '0;
      for (int k = 0; k < C; k++) l_q[k] <= '0;
      a_q     <= '0;
      b_q     <= '0;
      i_q     <= '0;
      j_q     <= '0;
      step_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (bus.ks_start) begin
            for (int k = 0; k < C; k++) l_q[k] <= bus.key[8*k +: 8];
            i_q     <= '0;
            valid_q <= 1'b0;
            busy_q  <= 1'b1;
            state_q <= StInit;
          end
        end
        StInit: begin
          s_q[i_q] <= P8 + Q8 * W'(i_q);
          if (i_q == ILast) begin
            i_q     <= '0;
            j_q     <= '0;
            a_q     <= '0;
            b_q     <= '0;
            step_q  <= '0;
            state_q <= StMix;
          end else begin
            i_q <= i_q + AW'(1);
          end
        end
        StMix: begin
          s_q[i_q] <= a_new;
          l_q[j_q] <= b_new;
          a_q      <= a_new;
          b_q      <= b_new;
          i_q      <= (i_q == ILast) ? '0 : i_q + AW'(1);
          j_q      <= (j_q == JLast) ? '0 : j_q + JW'(1);
          step_q   <= step_q + NW'(1);
          if (step_q == NLast) begin
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            valid_q <= 1'b1;
            state_q <= StDone;
          end
        end
        StDone: begin
          done_q  <= 1'b0;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // Zero-latency table read; out-of-range indices read as zero.
  always_comb begin
    bus.s_data = '0;
    if (32'(bus.s_addr) < T) bus.s_data = s_q[bus.s_addr];
  end

  assign bus.ks_busy  = busy_q;
  assign bus.ks_done  = done_q;
  assign bus.ks_valid = valid_q;

endmodule

// File: tb/tb_rc5_key_sched_8bit.sv
// Randomised bench for rc5_key_sched_8bit against a plain-arithmetic RC5 model.
module tb_rc5_key_sched_8bit;

  localparam int T = 26;
  localparam int C = 8;
  localparam int N = 78;

  logic clock;
  logic reset;

  rc5_key_sched_8bit_if #(.ROUNDS(12), .KEY_BYTES(8)) bus ();

  rc5_key_sched_8bit #(.ROUNDS(12), .KEY_BYTES(8)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int tests = 0;
  int fails = 0;
  int done_seen = 0;

  // Model state: expected table of the run in flight and status timeline.
  logic [7:0] exp_s [32];
  int  m_l0;
  bit  m_active, m_busy, m_done, m_valid, m_cleared;
  int  m_k;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    tests++;
    if (act !== expv) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
    end
  endtask

  function automatic int rol(input int x, input int n);
    return ((x << n) | (x >> (8 - n))) & 255;
  endfunction

  // Straight RC5 key expansion, stopped after 'steps' mix steps.
  function automatic void model_expand(input logic [63:0] k_in, input int steps);
    int s [T];
    int l [C];
    int a = 0, b = 0, i = 0, j = 0;
    for (int n = 0; n < C; n++) l[n] = int'(k_in[8*n +: 8]);
    for (int n = 0; n < T; n++) s[n] = (183 + n * 159) % 256;
    for (int n = 0; n < steps; n++) begin
      a = rol((s[i] + a + b) % 256, 3);
      s[i] = a;
      b = rol((l[j] + a + b) % 256, (a + b) % 8);
      l[j] = b;
      i = (i + 1) % T;
      j = (j + 1) % C;
    end
    for (int n = 0; n < 32; n++) exp_s[n] = (n < T) ? 8'(s[n]) : 8'h00;
    m_l0 = l[0];
  endfunction

  task automatic model_reset();
    m_active = 0; m_busy = 0; m_done = 0; m_valid = 0; m_cleared = 1; m_k = 0;
    for (int n = 0; n < 32; n++) exp_s[n] = 8'h00;
  endtask

  task automatic model_step();
    if (m_active) begin
      m_k++;
      if (m_k == T + N) begin
        m_busy = 0; m_done = 1; m_valid = 1;
      end else if (m_k == T + N + 1) begin
        m_done = 0; m_active = 0;
      end
    end else if (bus.ks_start) begin
      m_active = 1; m_k = 0; m_busy = 1; m_valid = 0; m_done = 0; m_cleared = 0;
      model_expand(bus.key, N);
    end
  endtask

  function automatic logic [7:0] exp_read(input int a);
    if (a >= T || (m_cleared && !m_active)) return 8'h00;
    return exp_s[a];
  endfunction

  task automatic compare_cycle();
    chk("ks_busy", 32'(bus.ks_busy), 32'(m_busy));
    chk("ks_done", 32'(bus.ks_done), 32'(m_done));
    chk("ks_valid", 32'(bus.ks_valid), 32'(m_valid));
    if (bus.ks_done === 1'b1) done_seen++;
    if (int'(bus.s_addr) >= T || (m_cleared && !m_active) || m_valid)
      chk("s_data", 32'(bus.s_data), 32'(exp_read(int'(bus.s_addr))));
  endtask

  // One clock: compare at the falling edge, advance the model at the rising edge.
  task automatic tick();
    @(negedge clock);
    compare_cycle();
    @(posedge clock);
    if (reset) model_step();
    #1;
    bus.s_addr = 5'($urandom_range(0, 31));
  endtask

  task automatic start_run(input logic [63:0] k);
    bus.key = k;
    done_seen = 0;
    bus.ks_start = 1'b1;
    tick();
    bus.ks_start = 1'b0;
  endtask

  task automatic finish_run(input int already);
    repeat (T + N + 1 - already) tick();
    chk("done_pulses", 32'(done_seen), 32'd1);
  endtask

  task automatic sweep(input string name);
    for (int a = 0; a < 32; a++) begin
      tick();
      bus.s_addr = 5'(a);
      #1;
      chk(name, 32'(bus.s_data), 32'(exp_read(a)));
    end
  endtask

  task automatic peek(input string name, input int a, input logic [7:0] expv);
    bus.s_addr = 5'(a);
    #1;
    chk(name, 32'(bus.s_data), 32'(expv));
  endtask

  initial begin
    logic [63:0] k;

    // Pin the model against hand-computed values.
    model_expand(64'h0, 0);
    chk("model_s0_init", 32'(exp_s[0]), 32'h0B7);
    chk("model_s1_init", 32'(exp_s[1]), 32'h056);
    chk("model_s25_init", 32'(exp_s[25]), 32'h03E);
    model_expand(64'h0, 1);
    chk("model_s0_mix1", 32'(exp_s[0]), 32'h0BD);
    chk("model_l0_mix1", 32'(m_l0), 32'h0B7);

    bus.ks_start = 1'b0;
    bus.key = '0;
    bus.s_addr = '0;
    reset = 1'b1;
    #2 reset = 1'b0;
    model_reset();
    repeat (3) @(posedge clock);
    #1 reset = 1'b1;

    // Idle after reset: flags low, whole table reads zero.
    sweep("reset_table");

    // All-zero key with intermediate table checks.
    start_run(64'h0);
    repeat (26) tick();
    peek("e26_s0", 0, 8'hB7);
    peek("e26_s1", 1, 8'h56);
    peek("e26_s25", 25, 8'h3E);
    tick();
    peek("e27_s0", 0, 8'hBD);
    chk("e27_l0", 32'(dut.l_q[0]), 32'h0B7);
    finish_run(27);
    sweep("table_zero_key");

    // All-ones key.
    start_run(64'hFFFF_FFFF_FFFF_FFFF);
    finish_run(0);
    sweep("table_ones_key");

    // Random key, key scrambled after capture, extra starts at E10 and E50.
    k = {$urandom, $urandom};
    start_run(k);
    bus.key = {$urandom, $urandom};
    repeat (9) tick();
    bus.ks_start = 1'b1;
    tick();
    bus.ks_start = 1'b0;
    repeat (39) tick();
    bus.ks_start = 1'b1;
    tick();
    bus.ks_start = 1'b0;
    finish_run(50);
    sweep("table_rand_key");

    // Abort with reset at E60, then restart.
    start_run({$urandom, $urandom});
    repeat (60) tick();
    reset = 1'b0;
    model_reset();
    #1;
    chk("abort_valid", 32'(bus.ks_valid), 32'd0);
    chk("abort_busy", 32'(bus.ks_busy), 32'd0);
    peek("abort_s0", 0, 8'h00);
    repeat (2) tick();
    reset = 1'b1;
    chk("abort_no_done", 32'(done_seen), 32'd0);
    sweep("abort_table");
    start_run({$urandom, $urandom});
    finish_run(0);
    sweep("table_restart");

    // Old key held after done, then a new key; valid drops on acceptance.
    repeat (5) tick();
    start_run({$urandom, $urandom});
    #1;
    chk("new_run_valid_low", 32'(bus.ks_valid), 32'd0);
    finish_run(0);
    sweep("table_new_key");
    for (int a = 26; a < 32; a++) peek("oob_zero", a, 8'h00);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
